// File: rtl/multi_channel_ddfs.sv
// Time-multiplexed NUM_CH-channel complex DDFS sharing one quarter-wave sine ROM, 3-stage valid/ready pipeline.
// Define DDFS_PHASE_DITHER_EN to add LFSR phase dither ahead of truncation; default build is pure truncation.
module multi_channel_ddfs #(
  parameter int NUM_CH     = 4,
  parameter int ACC_W      = 32,
  parameter int LUT_ADDR_W = 10,
  parameter int DATA_W     = 16,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_we,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [1:0]        i_cfg_sel,
  input  logic [ACC_W-1:0]  i_cfg_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [CH_W-1:0]   o_ch,
  output logic [DATA_W-1:0] o_real,
  output logic [DATA_W-1:0] o_imag
);
  localparam int  IDX_W = LUT_ADDR_W + 2;
  localparam int  DEPTH = 1 << LUT_ADDR_W;
  localparam real PI    = 3.14159265358979323846;
  localparam real AMP   = (2.0 ** (DATA_W - 1)) - 1.0;

  // Quarter-wave table, entry k = round(AMP * sin(pi/2 * k / DEPTH)), built at elaboration.
  logic [DATA_W-1:0] lut_rom [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_lut
    localparam int VAL = $rtoi(AMP * $sin(PI * k / (2.0 * DEPTH)) + 0.5);
    assign lut_rom[k] = DATA_W'(VAL);
  end

  logic [ACC_W-1:0]  acc_q  [NUM_CH];
  logic [ACC_W-1:0]  acc_d  [NUM_CH];
  logic [ACC_W-1:0]  freq_q [NUM_CH];
  logic [ACC_W-1:0]  freq_d [NUM_CH];
  logic [ACC_W-1:0]  off_q  [NUM_CH];
  logic [ACC_W-1:0]  off_d  [NUM_CH];
  logic [2:0]        ctrl_q [NUM_CH];
  logic [2:0]        ctrl_d [NUM_CH];
  logic [CH_W-1:0]   slot_q, slot_d;

  logic              p1_valid_q, p1_valid_d, p1_en_q, p1_en_d;
  logic [CH_W-1:0]   p1_ch_q, p1_ch_d;
  logic [IDX_W-1:0]  p1_idx_q, p1_idx_d;
  logic [1:0]        p1_inv_q, p1_inv_d;

  logic              p2_valid_q, p2_valid_d, p2_en_q, p2_en_d;
  logic [CH_W-1:0]   p2_ch_q, p2_ch_d;
  logic [DATA_W-1:0] p2_sin_q, p2_sin_d, p2_cos_q, p2_cos_d;
  logic              p2_neg_s_q, p2_neg_s_d, p2_neg_c_q, p2_neg_c_d;

  logic              o_valid_q, o_valid_d;
  logic [CH_W-1:0]   o_ch_q, o_ch_d;
  logic [DATA_W-1:0] o_real_q, o_real_d, o_imag_q, o_imag_d;

  logic              advance, cfg_ok;
  logic [ACC_W-1:0]  phase, dither;
  logic [1:0]        q, qs, qc;
  logic [LUT_ADDR_W-1:0] a, addr_s, addr_c;

  assign advance = !(o_valid_q && !i_ready);
  assign cfg_ok  = i_cfg_we && (int'(i_cfg_ch) < NUM_CH);

`ifdef DDFS_PHASE_DITHER_EN
  localparam int DITH_W = ((ACC_W - IDX_W) > 16) ? 16 : (ACC_W - IDX_W);
  logic [15:0] lfsr_q, lfsr_d;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end
  assign dither = ACC_W'(lfsr_q[DITH_W-1:0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign dither = '0;
`endif

  // S1 address map: odd quadrant mirrors the table, quadrant bit 1 negates in S2.
  assign q      = p1_idx_q[IDX_W-1 -: 2];
  assign a      = p1_idx_q[LUT_ADDR_W-1:0];
  assign qs     = q + {p1_inv_q[0], 1'b0};
  assign qc     = q + (p1_inv_q[1] ? 2'd3 : 2'd1);
  assign addr_s = qs[0] ? ~a : a;
  assign addr_c = qc[0] ? ~a : a;

  always_comb begin
    // NOTE: every _d starts from its hold value so no branch can leave it unassigned and infer a latch.
    acc_d      = acc_q;
    freq_d     = freq_q;
    off_d      = off_q;
    ctrl_d     = ctrl_q;
    slot_d     = slot_q;
    p1_valid_d = p1_valid_q;
    p1_en_d    = p1_en_q;
    p1_ch_d    = p1_ch_q;
    p1_idx_d   = p1_idx_q;
    p1_inv_d   = p1_inv_q;
    p2_valid_d = p2_valid_q;
    p2_en_d    = p2_en_q;
    p2_ch_d    = p2_ch_q;
    p2_sin_d   = p2_sin_q;
    p2_cos_d   = p2_cos_q;
    p2_neg_s_d = p2_neg_s_q;
    p2_neg_c_d = p2_neg_c_q;
    o_valid_d  = o_valid_q;
    o_ch_d     = o_ch_q;
    o_real_d   = o_real_q;
    o_imag_d   = o_imag_q;
    phase      = acc_q[slot_q] + off_q[slot_q] + dither;

    if (advance) begin
      slot_d     = (slot_q == CH_W'(NUM_CH - 1)) ? '0 : slot_q + 1'b1;
      if (ctrl_q[slot_q][0]) acc_d[slot_q] = acc_q[slot_q] + freq_q[slot_q];
      p1_valid_d = 1'b1;
      p1_ch_d    = slot_q;
      p1_idx_d   = IDX_W'(phase >> (ACC_W - IDX_W));
      p1_inv_d   = ctrl_q[slot_q][2:1];
      p1_en_d    = ctrl_q[slot_q][0];

      p2_valid_d = p1_valid_q;
      p2_ch_d    = p1_ch_q;
      p2_en_d    = p1_en_q;
      p2_sin_d   = lut_rom[addr_s];
      p2_cos_d   = lut_rom[addr_c];
      p2_neg_s_d = qs[1];
      p2_neg_c_d = qc[1];

      o_valid_d  = p2_valid_q;
      o_ch_d     = p2_ch_q;
      o_real_d   = p2_en_q ? (p2_neg_c_q ? -p2_cos_q : p2_cos_q) : '0;
      o_imag_d   = p2_en_q ? (p2_neg_s_q ? -p2_sin_q : p2_sin_q) : '0;
    end

    // Config lands even while stalled; a clear overrides this cycle's accumulate.
    if (cfg_ok) begin
      case (i_cfg_sel)
        2'b00:   freq_d[i_cfg_ch] = i_cfg_data;
        2'b01:   off_d[i_cfg_ch]  = i_cfg_data;
        2'b10:   ctrl_d[i_cfg_ch] = i_cfg_data[2:0];
        default: acc_d[i_cfg_ch]  = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the per-channel arrays are small flop banks and are cleared here; the ROM is constant and needs no reset.
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]  <= '0;
        freq_q[c] <= '0;
        off_q[c]  <= '0;
        ctrl_q[c] <= '0;
      end
      slot_q     <= '0;
      p1_valid_q <= 1'b0;
      p1_en_q    <= 1'b0;
      p1_ch_q    <= '0;
      p1_idx_q   <= '0;
      p1_inv_q   <= '0;
      p2_valid_q <= 1'b0;
      p2_en_q    <= 1'b0;
      p2_ch_q    <= '0;
      p2_sin_q   <= '0;
      p2_cos_q   <= '0;
      p2_neg_s_q <= 1'b0;
      p2_neg_c_q <= 1'b0;
      o_valid_q  <= 1'b0;
      o_ch_q     <= '0;
      o_real_q   <= '0;
      o_imag_q   <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking <= only; next-state math stays in always_comb.
      acc_q      <= acc_d;
      freq_q     <= freq_d;
      off_q      <= off_d;
      ctrl_q     <= ctrl_d;
      slot_q     <= slot_d;
      p1_valid_q <= p1_valid_d;
      p1_en_q    <= p1_en_d;
      p1_ch_q    <= p1_ch_d;
      p1_idx_q   <= p1_idx_d;
      p1_inv_q   <= p1_inv_d;
      p2_valid_q <= p2_valid_d;
      p2_en_q    <= p2_en_d;
      p2_ch_q    <= p2_ch_d;
      p2_sin_q   <= p2_sin_d;
      p2_cos_q   <= p2_cos_d;
      p2_neg_s_q <= p2_neg_s_d;
      p2_neg_c_q <= p2_neg_c_d;
      o_valid_q  <= o_valid_d;
      o_ch_q     <= o_ch_d;
      o_real_q   <= o_real_d;
      o_imag_q   <= o_imag_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_ch    = o_ch_q;
  assign o_real  = o_real_q;
  assign o_imag  = o_imag_q;

endmodule

// File: tb/tb_multi_channel_ddfs.sv
// Scoreboard bench for multi_channel_ddfs (4 channels, 32-bit phase, 1024-entry quarter LUT, dither off).
module tb_multi_channel_ddfs;
  localparam real PI = 3.14159265358979323846;
  localparam logic [15:0] M_POS = 16'd32767;
  localparam logic [15:0] M_NEG = 16'h8001;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cfg_we;
  logic [1:0]  i_cfg_ch;
  logic [1:0]  i_cfg_sel;
  logic [31:0] i_cfg_data;
  logic        i_ready;
  logic        o_valid;
  logic [1:0]  o_ch;
  logic [15:0] o_real;
  logic [15:0] o_imag;

  multi_channel_ddfs dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch),
    .i_cfg_sel(i_cfg_sel), .i_cfg_data(i_cfg_data), .i_ready(i_ready),
    .o_valid(o_valid), .o_ch(o_ch), .o_real(o_real), .o_imag(o_imag)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] re;
    logic [15:0] im;
  } sample_t;

  sample_t     sb[$];
  int          lut [1024];
  logic [31:0] m_acc [4];
  logic [31:0] m_freq [4];
  logic [31:0] m_off [4];
  logic [2:0]  m_ctrl [4];
  int          m_slot;
  int          model_cnt [4];
  int          dut_cnt [4];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [15:0] quad_val(int qq, int a);
    case (qq & 3)
      0:       return 16'(lut[a]);
      1:       return 16'(lut[1023 - a]);
      2:       return 16'(-lut[a]);
      default: return 16'(-lut[1023 - a]);
    endcase
  endfunction

  function automatic sample_t model_sample(int ch, logic [31:0] phase, logic [2:0] ctrl);
    sample_t s;
    int idx;
    idx  = int'(phase >> 20);
    s.ch = 2'(ch);
    if (!ctrl[0]) begin
      s.re = '0;
      s.im = '0;
    end else begin
      s.im = quad_val((idx >> 10) + (ctrl[1] ? 2 : 0), idx & 1023);
      s.re = quad_val((idx >> 10) + (ctrl[2] ? 3 : 1), idx & 1023);
    end
    return s;
  endfunction

  task automatic model_reset();
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      m_acc[c] = '0; m_freq[c] = '0; m_off[c] = '0; m_ctrl[c] = '0;
    end
    m_slot = 0;
  endtask

  // One clock: score the present output, drive inputs, advance the model, then wait for the next negedge.
  task automatic step(input logic rst, input logic we, input logic [1:0] ch, input logic [1:0] sel,
                      input logic [31:0] data, input logic rdy);
    logic mval;
    mval = (sb.size() == 3);
    n_checks++;
    if (o_valid !== mval) begin
      n_fail++;
      $display("FAIL sb_valid: o_valid=%b expected %b at %0t", o_valid, mval, $time);
    end
    if (mval) begin
      n_checks++;
      if ({o_ch, o_real, o_imag} !== sb[0]) begin
        n_fail++;
        $display("FAIL sb_sample: got ch=%0d re=%h im=%h, expected ch=%0d re=%h im=%h at %0t",
                 o_ch, o_real, o_imag, sb[0].ch, sb[0].re, sb[0].im, $time);
      end
    end
    i_rst = rst; i_cfg_we = we; i_cfg_ch = ch; i_cfg_sel = sel; i_cfg_data = data; i_ready = rdy;
    if (rst) begin
      model_reset();
    end else begin
      if (o_valid === 1'b1 && rdy) dut_cnt[o_ch]++;
      if (mval && rdy) begin
        model_cnt[sb[0].ch]++;
        void'(sb.pop_front());
      end
      if (!(mval && !rdy)) begin
        sb.push_back(model_sample(m_slot, m_acc[m_slot] + m_off[m_slot], m_ctrl[m_slot]));
        if (m_ctrl[m_slot][0]) m_acc[m_slot] = m_acc[m_slot] + m_freq[m_slot];
        m_slot = (m_slot + 1) % 4;
      end
      if (we) begin
        case (sel)
          2'b00:   m_freq[ch] = data;
          2'b01:   m_off[ch]  = data;
          2'b10:   m_ctrl[ch] = data[2:0];
          default: m_acc[ch]  = '0;
        endcase
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle(int n, logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 2'd0, 32'd0, rdy);
  endtask

  task automatic cfg_write(logic [1:0] ch, logic [1:0] sel, logic [31:0] data);
    step(1'b0, 1'b1, ch, sel, data, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 1'b1);
    n_checks++;
    if ({o_valid, o_ch, o_real, o_imag} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b ch=%0d re=%h im=%h, expected all zero", o_valid, o_ch, o_real, o_imag);
    end
    idle(12, 1'b1);
  endtask

  task automatic test_single_tone();
    cfg_write(2'd0, 2'b00, 32'h4000_0000);
    cfg_write(2'd0, 2'b10, 32'd1);
    idle(40, 1'b1);
  endtask

  task automatic test_inverted();
    bit seen;
    seen = 1'b0;
    cfg_write(2'd2, 2'b10, 32'd7);
    idle(8, 1'b1);
    for (int i = 0; i < 8 && !seen; i++) begin
      if (o_valid === 1'b1 && o_ch === 2'd2) begin
        seen = 1'b1;
        n_checks++;
        if (o_real !== M_NEG || o_imag !== 16'd0) begin
          n_fail++;
          $display("FAIL inverted_ch2: got re=%h im=%h, expected re=%h im=0000", o_real, o_imag, M_NEG);
        end
      end
      idle(1, 1'b1);
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL inverted_ch2: no ch2 sample within 8 cycles");
    end
    idle(12, 1'b1);
  endtask

  task automatic test_stall();
    logic [34:0] held;
    cfg_write(2'd1, 2'b00, 32'h0123_4567);
    cfg_write(2'd1, 2'b10, 32'd1);
    idle(6, 1'b1);
    held = {o_valid, o_ch, o_real, o_imag};
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b0);
      n_checks++;
      if ({o_valid, o_ch, o_real, o_imag} !== held) begin
        n_fail++;
        $display("FAIL stall_hold: got %h, held value %h (stall cycle %0d)", {o_valid, o_ch, o_real, o_imag}, held, i);
      end
    end
    idle(20, 1'b1);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (dut_cnt[c] !== model_cnt[c]) begin
        n_fail++;
        $display("FAIL stall_count ch%0d: accepted %0d, expected %0d", c, dut_cnt[c], model_cnt[c]);
      end
    end
  endtask

  task automatic test_clear();
    cfg_write(2'd1, 2'b01, 32'h2000_0000);
    idle(9, 1'b1);
    for (int i = 0; i < 4 && m_slot != 1; i++) idle(1, 1'b1);
    cfg_write(2'd1, 2'b11, 32'd0);
    idle(16, 1'b1);
  endtask

  task automatic test_mid_reset();
    bit seen;
    seen = 1'b0;
    idle(5, 1'b1);
    step(1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 1'b1);
    n_checks++;
    if ({o_valid, o_ch, o_real, o_imag} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: valid=%b ch=%0d re=%h im=%h, expected all zero", o_valid, o_ch, o_real, o_imag);
    end
    step(1'b1, 1'b0, 2'd0, 2'd0, 32'd0, 1'b1);
    for (int i = 0; i < 6 && !seen; i++) begin
      if (o_valid === 1'b1) begin
        seen = 1'b1;
        n_checks++;
        if (o_ch !== 2'd0 || i != 3) begin
          n_fail++;
          $display("FAIL midreset_restart: first valid ch=%0d after %0d cycles, expected ch=0 after 3", o_ch, i);
        end
      end
      if (!seen) idle(1, 1'b1);
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL midreset_restart: no valid within 6 cycles");
    end
    idle(8, 1'b1);
  endtask

  task automatic test_wrap();
    cfg_write(2'd3, 2'b00, 32'hFFFF_FFFF);
    cfg_write(2'd3, 2'b01, 32'h0000_0000);
    cfg_write(2'd3, 2'b10, 32'd3);
    cfg_write(2'd0, 2'b00, 32'h0765_4321);
    cfg_write(2'd0, 2'b10, 32'd5);
    for (int i = 0; i < 4 * (1024 + 8); i++) idle(1, ($urandom_range(0, 7) != 0));
    idle(4, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) lut[k] = $rtoi(32767.0 * $sin(PI * k / (2.0 * 1024)) + 0.5);
    for (int c = 0; c < 4; c++) begin
      model_cnt[c] = 0;
      dut_cnt[c] = 0;
    end
    model_reset();
    i_rst = 1'b1; i_cfg_we = 1'b0; i_cfg_ch = '0; i_cfg_sel = '0; i_cfg_data = '0; i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    test_reset();
    test_single_tone();
    test_inverted();
    test_stall();
    test_clear();
    test_mid_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
